// File: rtl/cpu_seq_pkg.sv
// Shared types and helpers for the multi-cycle CPU control sequencer.
// Holds the state encoding, the latched instruction class and the
// wait-counter width helper shared by the top and its counter.
package cpu_seq_pkg;

    // Sequencer states; the numeric codes are visible on state_o.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } seq_state_e;

    // Instruction class captured in DECODE and used for the rest of the instruction.
    typedef enum logic [2:0] {
        CLS_NOP   = 3'd0,
        CLS_ALU   = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_STORE = 3'd3,
        CLS_HALT  = 3'd4
    } instr_class_e;

    localparam int IMEM_WAIT_DEFAULT = 1;
    localparam int MEM_WAIT_DEFAULT  = 1;

    // Width needed to hold the longest wait (count runs from wait-1 down to 0).
    function automatic int wait_cnt_width(input int imem_wait, input int mem_wait);
        int longest;
        longest = (imem_wait > mem_wait) ? imem_wait : mem_wait;
        return $clog2(longest + 1);
    endfunction

    localparam int WAIT_CNT_W_DEFAULT = wait_cnt_width(IMEM_WAIT_DEFAULT, MEM_WAIT_DEFAULT);

    // Halt wins over everything; a store wins over a load when both are flagged.
    function automatic instr_class_e classify(input logic halt, input logic memwrite,
                                              input logic memread, input logic regwrite);
        instr_class_e cls;
        if (halt)
            cls = CLS_HALT;
        else if (memwrite)
            cls = CLS_STORE;
        else if (memread)
            cls = CLS_LOAD;
        else if (regwrite)
            cls = CLS_ALU;
        else
            cls = CLS_NOP;
        return cls;
    endfunction

endpackage

// File: rtl/cpu_sequencer_wait_counter.sv
// Loadable down-counter timing the multi-cycle FETCH and MEM phases.
// A phase of N cycles is loaded with N-1 and ends when the count reaches 0.
module seq_wait_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_last
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority over decrement; the count never goes below zero.
    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (dec && (count_q != '0))
            count_d = count_q - W'(1);
    end

    // Counter register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count   = count_q;
    assign is_last = (count_q == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and issues one-cycle strobes to the datapath.
// Optional single-step support is enabled with `define CPU_SEQ_SINGLE_STEP_EN.
// Strobes are Moore outputs with no handshake: each is high for exactly the
// cycle in which the datapath element must act.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int IMEM_WAIT = 1,
    parameter int MEM_WAIT  = 1,
    parameter int RETIRE_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
`ifdef CPU_SEQ_SINGLE_STEP_EN
    input  logic                step_mode,
    input  logic                step,
`endif
    input  logic                dec_regwrite,
    input  logic                dec_memwrite,
    input  logic                dec_memread,
    input  logic                dec_halt,
    output logic                ir_load,
    output logic                pc_en,
    output logic                rf_we,
    output logic                dm_we,
    output logic                busy,
    output logic                halted,
    output logic [2:0]          state_o,
    output logic [RETIRE_W-1:0] retired
);

    localparam int WAIT_W = wait_cnt_width(IMEM_WAIT, MEM_WAIT);
    localparam logic [WAIT_W-1:0] FETCH_LOAD = WAIT_W'(IMEM_WAIT - 1);
    localparam logic [WAIT_W-1:0] MEM_LOAD   = WAIT_W'(MEM_WAIT - 1);

    seq_state_e          state_q, state_d;
    instr_class_e        cls_q, cls_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;

    logic              cnt_load;
    logic [WAIT_W-1:0] cnt_load_val;
    logic              cnt_dec;
    logic [WAIT_W-1:0] cnt_val;
    logic              cnt_last;

    logic start_req;
    logic step_hold;
    logic ir_load_s, pc_en_s, rf_we_s, dm_we_s;

`ifdef CPU_SEQ_SINGLE_STEP_EN
    assign start_req = run | step;
    assign step_hold = step_mode;
`else
    assign start_req = run;
    assign step_hold = 1'b0;
`endif

    seq_wait_counter #(.W(WAIT_W)) u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .is_last  (cnt_last)
    );

    // Next-state, class latch, counter control and Moore strobes.
    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        cnt_load     = 1'b0;
        cnt_load_val = FETCH_LOAD;
        cnt_dec      = 1'b0;
        ir_load_s    = 1'b0;
        pc_en_s      = 1'b0;
        rf_we_s      = 1'b0;
        dm_we_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d  = ST_FETCH;
                    cnt_load = 1'b1;
                end
            end
            ST_FETCH: begin
                if (cnt_last) begin
                    ir_load_s = 1'b1;
                    state_d   = ST_DECODE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DECODE: begin
                cls_d   = classify(dec_halt, dec_memwrite, dec_memread, dec_regwrite);
                state_d = (cls_d == CLS_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_LOAD, CLS_STORE: begin
                        state_d      = ST_MEM;
                        cnt_load     = 1'b1;
                        cnt_load_val = MEM_LOAD;
                    end
                    CLS_ALU: state_d = ST_WB;
                    default: begin
                        pc_en_s  = 1'b1;
                        state_d  = step_hold ? ST_IDLE : ST_FETCH;
                        cnt_load = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                // The write fires once, on entry, however long the memory takes.
                dm_we_s = (cls_q == CLS_STORE) && (cnt_val == MEM_LOAD);
                if (cnt_last) begin
                    if (cls_q == CLS_STORE) begin
                        pc_en_s  = 1'b1;
                        state_d  = step_hold ? ST_IDLE : ST_FETCH;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WB: begin
                rf_we_s  = 1'b1;
                pc_en_s  = 1'b1;
                state_d  = step_hold ? ST_IDLE : ST_FETCH;
                cnt_load = 1'b1;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
        retired_d = retired_q + RETIRE_W'(pc_en_s);
    end

    // State, class and retired-count registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cls_q     <= CLS_NOP;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            retired_q <= retired_d;
        end
    end

    // Write enables are cut while reset is low so a reset mid-MEM/WB blocks the write.
    assign ir_load = ir_load_s;
    assign pc_en   = pc_en_s;
    assign rf_we   = rf_we_s & reset;
    assign dm_we   = dm_we_s & reset;
    assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted  = (state_q == ST_HALT);
    assign state_o = state_q;
    assign retired = retired_q;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control sequencer for the processor datapath: PC, instruction memory, controller, regfile, ALU, data memory.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and issues one-cycle strobes to the stateful elements: ir_load, pc_en, rf_we, dm_we.
- The decoder's regwrite/memwrite become requests; this block decides when they take effect.
- Also tracks halt, busy and the retired-instruction count.

Parameters:
- IMEM_WAIT, 1, cycles spent in FETCH (≥1); instruction memory read latency.
- MEM_WAIT, 1, cycles spent in MEM (≥1); data memory access latency.
- RETIRE_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- run  in  1  start request; sampled in IDLE only.
- dec_regwrite  in  1  decoded instruction writes the regfile.
- dec_memwrite  in  1  decoded instruction is a store.
- dec_memread  in  1  decoded instruction is a load (result selected from data memory).
- dec_halt  in  1  decoded instruction is HALT.
- ir_load  out  1  latch instruction register.
- pc_en  out  1  advance PC.
- rf_we  out  1  regfile write enable.
- dm_we  out  1  data memory write enable.
- busy  out  1  state is neither IDLE nor HALT.
- halted  out  1  state is HALT.
- state_o  out  3  current state encoding.
- retired  out  RETIRE_W  retired-instruction count.

Behaviour:
- Reset: sampled at the clock edge while reset==0.
  - Next state is IDLE; wait counter, latched class and retired are cleared.
  - All outputs are 0 after reset; state_o=0.
  - rf_we and dm_we are additionally forced 0 combinationally while reset==0, so reset asserted mid-MEM or mid-WB blocks the write in that same cycle.
- Encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Codes 7 and above go to IDLE on the next edge.
- Strobes are Moore outputs, decoded from state and wait counter.
- IDLE: run==1 → FETCH. Otherwise stay.
- FETCH: occupies IMEM_WAIT cycles, counted by the wait counter. ir_load=1 in the last FETCH cycle only. Then → DECODE.
- DECODE: one cycle. Latches class from the dec_* inputs into an internal register.
  - dec_halt has priority: → HALT.
  - Otherwise → EXEC.
  - dec_memread and dec_memwrite both 1: treat as store; the load is ignored.
- EXEC: one cycle.
  - load or store → MEM.
  - else regwrite → WB.
  - else (nop-class): pc_en=1 this cycle, → FETCH.
- MEM: occupies MEM_WAIT cycles.
  - Store: dm_we=1 in the first MEM cycle only; pc_en=1 in the last MEM cycle; then → FETCH.
  - Load: no dm_we; → WB after the last MEM cycle.
- WB: one cycle. rf_we=1 and pc_en=1 together, → FETCH.
- HALT: absorbing; run is ignored. Exit only via reset.
- Retired counter: increments on every cycle with pc_en=1. Wraps from 2^RETIRE_W−1 to 0.
- Cycle counts at default parameters:
  - nop-class: 3
  - store: 4
  - ALU: 4
  - load: 5
- General rule: cycles = IMEM_WAIT + 2 + MEM_WAIT·(mem op) + (WB present).
- Constraints:
  - dec_* inputs are read only in DECODE; changes elsewhere have no effect.
  - At most one of pc_en and ir_load is high in any cycle.

Optional Feature:
- Macro: CPU_SEQ_SINGLE_STEP_EN.
- When defined, adds two inputs:
  - step_mode (1 bit): when 1, the sequencer goes to IDLE instead of FETCH after any pc_en cycle.
  - step (1 bit): a pulse in IDLE behaves like run.
- When not defined, both ports are absent and the sequencer runs continuously from FETCH to FETCH.

Decomposition:
- Package cpu_seq_pkg holds:
  - state enum and its 3-bit encoding;
  - instruction-class enum: NOP, ALU, LOAD, STORE, HALT;
  - wait-counter width constant derived as $clog2 of max(IMEM_WAIT, MEM_WAIT)+1.
- One sub-module: seq_wait_counter.
  - Loadable down-counter: load value, dec, is_last.
  - Shared by FETCH and MEM.

Test Plan:
- Reset and idle: reset=0 for 2 cycles, then 1, run=0 for 10 cycles → state_o=0, all strobes 0, retired=0, busy=0.
- ALU instruction, defaults: run pulse, dec_regwrite=1 → ir_load in cycle 1, rf_we and pc_en together in cycle 4, retired=1, state_o=1 in cycle 5.
- Load, MEM_WAIT=3: dec_memread=1, dec_regwrite=1 → MEM for 3 cycles, dm_we never high, rf_we in cycle 7, retired increments once.
- Store, MEM_WAIT=2: dec_memwrite=1 → dm_we high in exactly cycle 4, pc_en in cycle 5, rf_we never high.
- Halt and wrap: RETIRE_W=2, run 4 nop-class instructions then dec_halt=1 → retired sequence 1,2,3,0; halted=1; further run pulses ignored; reset → IDLE.
- Reset mid-store: MEM_WAIT=2, reset driven low in the first MEM cycle → dm_we=0 in that cycle, state_o=0 next cycle, retired=0.
